// File: rtl/joybus_cons_cmd_decoder.sv
// Console-side Joybus command decoder: pulse-width bit decode, frame checks, sticky status flags.
// Optional JB_GLITCH_FILTER_EN adds a 3-sample majority filter on the synchronized line.
module joybus_cons_cmd_decoder #(
  parameter int CLK_MHZ   = 50,
  parameter int THRESH_US = 2,
  parameter int LOWMAX_US = 6,
  parameter int IDLE_US   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       JB_RX,
  input  logic       reset_poll_status,
  input  logic       reset_cmd_done_status,
  output logic       console_did_poll,
  output logic       console_cmd_done,
  output logic [7:0] cmd_byte,
  output logic       rumble,
  output logic       frame_err
);
  localparam int THR   = THRESH_US * CLK_MHZ;
  localparam int LMAX  = LOWMAX_US * CLK_MHZ;
  localparam int IDLE  = IDLE_US * CLK_MHZ;
  localparam int CNT_W = $clog2((LMAX > IDLE) ? LMAX : IDLE) + 1;

  localparam logic [CNT_W-1:0] THR_C  = CNT_W'(THR);
  localparam logic [CNT_W-1:0] LMAX_C = CNT_W'(LMAX);
  localparam logic [CNT_W-1:0] IDLE_C = CNT_W'(IDLE);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_STOP, S_RESYNC} state_t;

  state_t           state;
  logic             rx_meta, rx_s, rx_line, rx_d;
  logic             rise, fall, bit_val, len24;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       bit_cnt;
  logic [4:0]       frame_len;
  logic [6:0]       shreg;
  logic [7:0]       byte_nxt, byte0;

  // Two-flop synchronizer; resets to the idle-high level so no false edge appears on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= JB_RX;
      rx_s    <= rx_meta;
    end
  end

`ifdef JB_GLITCH_FILTER_EN
  logic [1:0] rx_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_hist <= 2'b11;
      rx_line <= 1'b1;
    end else begin
      rx_hist <= {rx_hist[0], rx_s};
      rx_line <= (rx_s & rx_hist[0]) | (rx_s & rx_hist[1]) | (rx_hist[0] & rx_hist[1]);
    end
  end
`else
  assign rx_line = rx_s;
`endif

  // Edge detect and saturating level-duration counter; cnt equals cycles spent at the current level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d <= 1'b1;
      cnt  <= '0;
    end else begin
      rx_d <= rx_line;
      if (rise || fall)
        cnt <= CNT_W'(1);
      else if (cnt != CNT_SAT)
        cnt <= cnt + 1'b1;
    end
  end

  assign rise      = rx_line & ~rx_d;
  assign fall      = ~rx_line & rx_d;
  assign bit_val   = (cnt < THR_C);
  assign byte_nxt  = {shreg, bit_val};
  assign frame_len = len24 ? 5'd24 : 5'd8;

  // Received bits: only the first byte and the trailing bits are ever needed.
  always_ff @(posedge clk) begin
    if (state == S_LOW && rise) begin
      shreg <= byte_nxt[6:0];
      if (bit_cnt == 5'd7)
        byte0 <= byte_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      bit_cnt          <= '0;
      len24            <= 1'b0;
      console_did_poll <= 1'b0;
      console_cmd_done <= 1'b0;
      cmd_byte         <= '0;
      rumble           <= 1'b0;
      frame_err        <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      // Clears first so a same-cycle set below overrides them.
      if (reset_poll_status)
        console_did_poll <= 1'b0;
      if (reset_cmd_done_status)
        console_cmd_done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (fall) begin
            bit_cnt <= '0;
            state   <= S_LOW;
          end
        end
        S_LOW: begin
          if (rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            state   <= S_HIGH;
            if (bit_cnt == 5'd7) begin
              case (byte_nxt)
                8'h00, 8'h41: len24 <= 1'b0;
                8'h40, 8'h42: len24 <= 1'b1;
                default: begin
                  frame_err <= 1'b1;
                  state     <= S_RESYNC;
                end
              endcase
            end
          end else if (cnt > LMAX_C) begin
            frame_err <= 1'b1;
            state     <= S_RESYNC;
          end
        end
        S_HIGH: begin
          if (fall)
            state <= (bit_cnt == frame_len) ? S_STOP : S_LOW;
          else if (cnt > IDLE_C) begin
            frame_err <= 1'b1;
            state     <= S_RESYNC;
          end
        end
        S_STOP: begin
          if (rise) begin
            if (cnt < THR_C) begin
              console_cmd_done <= 1'b1;
              cmd_byte         <= byte0;
              if (byte0 == 8'h40) begin
                console_did_poll <= 1'b1;
                rumble           <= shreg[0];
              end
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_RESYNC;
            end
          end else if (cnt > LMAX_C) begin
            frame_err <= 1'b1;
            state     <= S_RESYNC;
          end
        end
        S_RESYNC: begin
          if (rx_line && cnt >= IDLE_C)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_joybus_cons_cmd_decoder.sv
// Directed bench for joybus_cons_cmd_decoder at 50 MHz: '1' = 50 low/150 high, '0' = 150 low/50 high.
module tb_joybus_cons_cmd_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       JB_RX = 1'b1;
  logic       reset_poll_status = 1'b0;
  logic       reset_cmd_done_status = 1'b0;
  logic       console_did_poll, console_cmd_done, rumble, frame_err;
  logic [7:0] cmd_byte;

  int checks = 0;
  int failures = 0;
  int err_cycles = 0;

  joybus_cons_cmd_decoder dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .JB_RX                 (JB_RX),
    .reset_poll_status     (reset_poll_status),
    .reset_cmd_done_status (reset_cmd_done_status),
    .console_did_poll      (console_did_poll),
    .console_cmd_done      (console_cmd_done),
    .cmd_byte              (cmd_byte),
    .rumble                (rumble),
    .frame_err             (frame_err)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) err_cycles++;

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    JB_RX = 1'b0;
    wait_clk(b ? 50 : 150);
    JB_RX = 1'b1;
    wait_clk(b ? 150 : 50);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // Leaves the line just after the stop-bit rise so callers can time the flag latency.
  task automatic send_stop_rise();
    JB_RX = 1'b0;
    wait_clk(50);
    JB_RX = 1'b1;
  endtask

  task automatic pulse_clear(input logic p, input logic d);
    reset_poll_status = p;
    reset_cmd_done_status = d;
    wait_clk(1);
    reset_poll_status = 1'b0;
    reset_cmd_done_status = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(3);
    checks++; if (console_did_poll !== 1'b0) begin failures++; $display("FAIL rst_poll got=%0b exp=0", console_did_poll); end
    checks++; if (console_cmd_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", console_cmd_done); end
    checks++; if (cmd_byte !== 8'h00) begin failures++; $display("FAIL rst_cmd got=%h exp=00", cmd_byte); end
    checks++; if (rumble !== 1'b0) begin failures++; $display("FAIL rst_rumble got=%0b exp=0", rumble); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", frame_err); end
    rst_n = 1'b1;
    wait_clk(10);
    checks++; if (err_cycles !== 0) begin failures++; $display("FAIL rst_release_err got=%0d exp=0", err_cycles); end
  endtask

  task automatic test_poll();
    int e0 = err_cycles;
    send_byte(8'h40); send_byte(8'h03); send_byte(8'h01);
    send_stop_rise();
    wait_clk(2);
    checks++; if (console_cmd_done !== 1'b0) begin failures++; $display("FAIL poll_early_done got=%0b exp=0", console_cmd_done); end
    checks++; if (console_did_poll !== 1'b0) begin failures++; $display("FAIL poll_early_poll got=%0b exp=0", console_did_poll); end
    wait_clk(1);
    checks++; if (console_cmd_done !== 1'b1) begin failures++; $display("FAIL poll_done got=%0b exp=1", console_cmd_done); end
    checks++; if (console_did_poll !== 1'b1) begin failures++; $display("FAIL poll_poll got=%0b exp=1", console_did_poll); end
    checks++; if (cmd_byte !== 8'h40) begin failures++; $display("FAIL poll_cmd got=%h exp=40", cmd_byte); end
    checks++; if (rumble !== 1'b1) begin failures++; $display("FAIL poll_rumble got=%0b exp=1", rumble); end
    checks++; if (err_cycles - e0 !== 0) begin failures++; $display("FAIL poll_err got=%0d exp=0", err_cycles - e0); end
    wait_clk(20);
  endtask

  task automatic test_info_clear();
    pulse_clear(1'b1, 1'b1);
    checks++; if (console_did_poll !== 1'b0) begin failures++; $display("FAIL clr_poll got=%0b exp=0", console_did_poll); end
    checks++; if (console_cmd_done !== 1'b0) begin failures++; $display("FAIL clr_done got=%0b exp=0", console_cmd_done); end
    send_byte(8'h00);
    send_stop_rise();
    wait_clk(3);
    checks++; if (console_cmd_done !== 1'b1) begin failures++; $display("FAIL info_done got=%0b exp=1", console_cmd_done); end
    checks++; if (console_did_poll !== 1'b0) begin failures++; $display("FAIL info_poll got=%0b exp=0", console_did_poll); end
    checks++; if (cmd_byte !== 8'h00) begin failures++; $display("FAIL info_cmd got=%h exp=00", cmd_byte); end
    checks++; if (rumble !== 1'b1) begin failures++; $display("FAIL info_rumble_hold got=%0b exp=1", rumble); end
    reset_cmd_done_status = 1'b1;
    wait_clk(1);
    reset_cmd_done_status = 1'b0;
    checks++; if (console_cmd_done !== 1'b0) begin failures++; $display("FAIL info_done_clr got=%0b exp=0", console_cmd_done); end
    wait_clk(20);
  endtask

  task automatic test_bad_byte();
    int e0 = err_cycles;
    send_byte(8'h55);
    checks++; if (err_cycles - e0 !== 1) begin failures++; $display("FAIL bad_byte_err got=%0d exp=1", err_cycles - e0); end
    checks++; if (console_cmd_done !== 1'b0) begin failures++; $display("FAIL bad_byte_done got=%0b exp=0", console_cmd_done); end
    checks++; if (cmd_byte !== 8'h00) begin failures++; $display("FAIL bad_byte_cmd got=%h exp=00", cmd_byte); end
    wait_clk(250);
    send_byte(8'h40); send_byte(8'h03); send_byte(8'h00);
    send_stop_rise();
    wait_clk(3);
    checks++; if (console_did_poll !== 1'b1) begin failures++; $display("FAIL recover_poll got=%0b exp=1", console_did_poll); end
    checks++; if (cmd_byte !== 8'h40) begin failures++; $display("FAIL recover_cmd got=%h exp=40", cmd_byte); end
    checks++; if (rumble !== 1'b0) begin failures++; $display("FAIL recover_rumble got=%0b exp=0", rumble); end
    wait_clk(20);
  endtask

  task automatic test_set_wins();
    pulse_clear(1'b1, 1'b0);
    checks++; if (console_did_poll !== 1'b0) begin failures++; $display("FAIL sw_pre_poll got=%0b exp=0", console_did_poll); end
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h01);
    send_stop_rise();
    wait_clk(2);
    reset_poll_status = 1'b1;
    wait_clk(1);
    reset_poll_status = 1'b0;
    checks++; if (console_did_poll !== 1'b1) begin failures++; $display("FAIL sw_poll got=%0b exp=1", console_did_poll); end
    checks++; if (rumble !== 1'b1) begin failures++; $display("FAIL sw_rumble got=%0b exp=1", rumble); end
    wait_clk(1);
    checks++; if (console_did_poll !== 1'b1) begin failures++; $display("FAIL sw_hold got=%0b exp=1", console_did_poll); end
    pulse_clear(1'b1, 1'b0);
    checks++; if (console_did_poll !== 1'b0) begin failures++; $display("FAIL sw_clr got=%0b exp=0", console_did_poll); end
    checks++; if (console_cmd_done !== 1'b1) begin failures++; $display("FAIL sw_done_kept got=%0b exp=1", console_cmd_done); end
    wait_clk(20);
  endtask

  task automatic test_truncated();
    int e0 = err_cycles;
    send_byte(8'h40);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    JB_RX = 1'b0;
    wait_clk(150);
    JB_RX = 1'b1;
    wait_clk(200);
    checks++; if (err_cycles - e0 !== 0) begin failures++; $display("FAIL trunc_early got=%0d exp=0", err_cycles - e0); end
    wait_clk(300);
    checks++; if (err_cycles - e0 !== 1) begin failures++; $display("FAIL trunc_err got=%0d exp=1", err_cycles - e0); end
    checks++; if (console_cmd_done !== 1'b1) begin failures++; $display("FAIL trunc_done got=%0b exp=1", console_cmd_done); end
    checks++; if (console_did_poll !== 1'b0) begin failures++; $display("FAIL trunc_poll got=%0b exp=0", console_did_poll); end
    checks++; if (cmd_byte !== 8'h40) begin failures++; $display("FAIL trunc_cmd got=%h exp=40", cmd_byte); end
  endtask

  task automatic test_mid_reset();
    int e0;
    send_bit(1'b1); send_bit(1'b0);
    JB_RX = 1'b0;
    wait_clk(20);
    rst_n = 1'b0;
    wait_clk(2);
    checks++; if ({console_did_poll, console_cmd_done, rumble, frame_err} !== 4'b0) begin failures++; $display("FAIL mid_rst_flags got=%b exp=0000", {console_did_poll, console_cmd_done, rumble, frame_err}); end
    checks++; if (cmd_byte !== 8'h00) begin failures++; $display("FAIL mid_rst_cmd got=%h exp=00", cmd_byte); end
    JB_RX = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(10);
    e0 = err_cycles;
    send_byte(8'h41);
    send_stop_rise();
    wait_clk(3);
    checks++; if (cmd_byte !== 8'h41) begin failures++; $display("FAIL mr_cmd got=%h exp=41", cmd_byte); end
    checks++; if (console_cmd_done !== 1'b1) begin failures++; $display("FAIL mr_done got=%0b exp=1", console_cmd_done); end
    checks++; if (console_did_poll !== 1'b0) begin failures++; $display("FAIL mr_poll got=%0b exp=0", console_did_poll); end
    checks++; if (err_cycles - e0 !== 0) begin failures++; $display("FAIL mr_err got=%0d exp=0", err_cycles - e0); end
    wait_clk(20);
  endtask

  task automatic test_long_low();
    int e0 = err_cycles;
    JB_RX = 1'b0;
    wait_clk(400);
    JB_RX = 1'b1;
    wait_clk(300);
    checks++; if (err_cycles - e0 !== 1) begin failures++; $display("FAIL long_low_err got=%0d exp=1", err_cycles - e0); end
    checks++; if (cmd_byte !== 8'h41) begin failures++; $display("FAIL long_low_cmd got=%h exp=41", cmd_byte); end
  endtask

  task automatic test_bad_stop();
    int e0;
    pulse_clear(1'b1, 1'b1);
    e0 = err_cycles;
    send_byte(8'h00);
    JB_RX = 1'b0;
    wait_clk(150);
    JB_RX = 1'b1;
    wait_clk(300);
    checks++; if (err_cycles - e0 !== 1) begin failures++; $display("FAIL bad_stop_err got=%0d exp=1", err_cycles - e0); end
    checks++; if (console_cmd_done !== 1'b0) begin failures++; $display("FAIL bad_stop_done got=%0b exp=0", console_cmd_done); end
    checks++; if (cmd_byte !== 8'h41) begin failures++; $display("FAIL bad_stop_cmd got=%h exp=41", cmd_byte); end
  endtask

  initial begin
    test_reset();
    test_poll();
    test_info_clear();
    test_bad_byte();
    test_set_wins();
    test_truncated();
    test_mid_reset();
    test_long_low();
    test_bad_stop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
